// File: rtl/hammu_axil_arbiter.sv
// hammu_axil_arbiter: shares the hammu_ip AXI4-Lite slave port between two
// hardware requesters. One single-beat read or write is in flight at a time.
// Build option: define HAMMU_ARB_RR_EN for round-robin arbitration; when it
// is left undefined, requester 0 wins every tie (fixed priority).
module hammu_axil_arbiter #(
    parameter logic [31:0] C_BASEADDR         = 32'h70e00000,
    parameter int          C_OFS_WIDTH        = 9,
    parameter int          C_M_AXI_DATA_WIDTH = 32
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESET,
    // requester side
    input  logic [1:0]                      REQ_VALID,
    input  logic [1:0]                      REQ_WE,
    input  logic [2*C_OFS_WIDTH-1:0]        REQ_ADDR,
    input  logic [2*C_M_AXI_DATA_WIDTH-1:0] REQ_WDATA,
    output logic [1:0]                      REQ_DONE,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   REQ_RDATA,
    output logic                            REQ_ERR,
    // AXI4-Lite write address / data / response
    output logic [31:0]                     M_AXI_AWADDR,
    output logic                            M_AXI_AWVALID,
    input  logic                            M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                            M_AXI_WVALID,
    input  logic                            M_AXI_WREADY,
    input  logic [1:0]                      M_AXI_BRESP,
    input  logic                            M_AXI_BVALID,
    output logic                            M_AXI_BREADY,
    // AXI4-Lite read address / data
    output logic [31:0]                     M_AXI_ARADDR,
    output logic                            M_AXI_ARVALID,
    input  logic                            M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                      M_AXI_RRESP,
    input  logic                            M_AXI_RVALID,
    output logic                            M_AXI_RREADY
);

    localparam int DW = C_M_AXI_DATA_WIDTH;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WR_AW = 3'd1,
        WR_B  = 3'd2,
        RD_AR = 3'd3,
        RD_R  = 3'd4,
        RESP  = 3'd5
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // latched transaction
    logic          r_grant;
    logic [31:0]   r_addr;
    logic [DW-1:0] r_wdata;
    logic [DW-1:0] r_rdata;
    logic          r_err;
    logic          r_aw_done;
    logic          r_w_done;

    // per-requester views of the packed request buses
    logic [C_OFS_WIDTH-1:0] w_ofs       [2];
    logic [DW-1:0]          w_req_wdata [2];
    logic [3:0]             w_unused_bits;
    logic                   w_unused;

    logic          w_grant;
    logic [31:0]   w_axi_addr;
    logic          w_aw_hs;
    logic          w_w_hs;
    logic          w_awvalid;
    logic          w_wvalid;
    logic          w_arvalid;
    logic          w_bready;
    logic          w_rready;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_req
            assign w_ofs[gi]       = REQ_ADDR[gi*C_OFS_WIDTH +: C_OFS_WIDTH];
            assign w_req_wdata[gi] = REQ_WDATA[gi*DW +: DW];
            // byte-lane bits of the offset carry no meaning for word accesses
            assign w_unused_bits[gi] = ^REQ_ADDR[gi*C_OFS_WIDTH +: 2];
            assign REQ_DONE[gi]    = (r_state == RESP) && (r_grant == 1'(gi));
        end
    endgenerate

    assign w_unused_bits[2] = M_AXI_BRESP[0];
    assign w_unused_bits[3] = M_AXI_RRESP[0];
    assign w_unused         = ^w_unused_bits;

    // Word-aligned AXI address of the request that would be granted now
    assign w_axi_addr = C_BASEADDR |
                        {{(32-C_OFS_WIDTH){1'b0}}, w_ofs[w_grant][C_OFS_WIDTH-1:2], 2'b00};

`ifdef HAMMU_ARB_RR_EN
    logic r_last;

    // On a tie, serve the requester that did not win the previous grant
    always_comb begin
        w_grant = REQ_VALID[1];
        if (&REQ_VALID) begin
            w_grant = ~r_last;
        end
    end

    // Remember the most recent winner; reset makes requester 0 first in line
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            r_last <= 1'b1;
        end else if ((r_state == IDLE) && (|REQ_VALID)) begin
            r_last <= w_grant;
        end
    end
`else
    // Fixed priority: requester 1 only wins when requester 0 is idle
    always_comb begin
        w_grant = ~REQ_VALID[0];
    end
`endif

    assign w_aw_hs = w_awvalid & M_AXI_AWREADY;
    assign w_w_hs  = w_wvalid  & M_AXI_WREADY;

    // State register
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and AXI channel control
    always_comb begin
        w_state_next = r_state;
        w_awvalid    = 1'b0;
        w_wvalid     = 1'b0;
        w_arvalid    = 1'b0;
        w_bready     = 1'b0;
        w_rready     = 1'b0;
        case (r_state)
            IDLE: begin
                if (|REQ_VALID) begin
                    w_state_next = REQ_WE[w_grant] ? WR_AW : RD_AR;
                end
            end
            WR_AW: begin
                // address and data channels retire independently
                w_awvalid = ~r_aw_done;
                w_wvalid  = ~r_w_done;
                if ((r_aw_done | (~r_aw_done & M_AXI_AWREADY)) &&
                    (r_w_done  | (~r_w_done  & M_AXI_WREADY))) begin
                    w_state_next = WR_B;
                end
            end
            WR_B: begin
                w_bready = 1'b1;
                if (M_AXI_BVALID) begin
                    w_state_next = RESP;
                end
            end
            RD_AR: begin
                w_arvalid = 1'b1;
                if (M_AXI_ARREADY) begin
                    w_state_next = RD_R;
                end
            end
            RD_R: begin
                w_rready = 1'b1;
                if (M_AXI_RVALID) begin
                    w_state_next = RESP;
                end
            end
            RESP: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Latch the granted request and collect the slave's response
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            r_grant   <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rdata   <= '0;
            r_err     <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (|REQ_VALID) begin
                        r_grant   <= w_grant;
                        r_addr    <= w_axi_addr;
                        r_wdata   <= w_req_wdata[w_grant];
                        // a write reports zero read data
                        r_rdata   <= '0;
                        r_err     <= 1'b0;
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                    end
                end
                WR_AW: begin
                    if (w_aw_hs) begin
                        r_aw_done <= 1'b1;
                    end
                    if (w_w_hs) begin
                        r_w_done <= 1'b1;
                    end
                end
                WR_B: begin
                    if (M_AXI_BVALID) begin
                        r_err <= M_AXI_BRESP[1];
                    end
                end
                RD_R: begin
                    if (M_AXI_RVALID) begin
                        r_rdata <= M_AXI_RDATA;
                        r_err   <= M_AXI_RRESP[1];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign M_AXI_AWADDR  = r_addr;
    assign M_AXI_ARADDR  = r_addr;
    assign M_AXI_WDATA   = r_wdata;
    assign M_AXI_WSTRB   = '1;
    assign M_AXI_AWVALID = w_awvalid;
    assign M_AXI_WVALID  = w_wvalid;
    assign M_AXI_ARVALID = w_arvalid;
    assign M_AXI_BREADY  = w_bready;
    assign M_AXI_RREADY  = w_rready;
    assign REQ_RDATA     = r_rdata;
    assign REQ_ERR       = r_err;

endmodule

// File: tb/tb_hammu_axil_arbiter.sv
// Directed testbench for hammu_axil_arbiter with a delay-programmable
// AXI4-Lite slave model. Grant-order expectations follow HAMMU_ARB_RR_EN.
module tb_hammu_axil_arbiter;

    logic        clk = 1'b0;
    logic        ARESET;
    logic [1:0]  REQ_VALID;
    logic [1:0]  REQ_WE;
    logic [17:0] REQ_ADDR;
    logic [63:0] REQ_WDATA;
    logic [1:0]  REQ_DONE;
    logic [31:0] REQ_RDATA;
    logic        REQ_ERR;
    logic [31:0] AWADDR;
    logic        AWVALID;
    logic        AWREADY = 1'b0;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WVALID;
    logic        WREADY = 1'b0;
    logic [1:0]  BRESP = 2'b00;
    logic        BVALID = 1'b0;
    logic        BREADY;
    logic [31:0] ARADDR;
    logic        ARVALID;
    logic        ARREADY = 1'b0;
    logic [31:0] RDATA = '0;
    logic [1:0]  RRESP = 2'b00;
    logic        RVALID = 1'b0;
    logic        RREADY;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    hammu_axil_arbiter dut (
        .S_AXI_ACLK   (clk),
        .S_AXI_ARESET (ARESET),
        .REQ_VALID    (REQ_VALID),
        .REQ_WE       (REQ_WE),
        .REQ_ADDR     (REQ_ADDR),
        .REQ_WDATA    (REQ_WDATA),
        .REQ_DONE     (REQ_DONE),
        .REQ_RDATA    (REQ_RDATA),
        .REQ_ERR      (REQ_ERR),
        .M_AXI_AWADDR (AWADDR),
        .M_AXI_AWVALID(AWVALID),
        .M_AXI_AWREADY(AWREADY),
        .M_AXI_WDATA  (WDATA),
        .M_AXI_WSTRB  (WSTRB),
        .M_AXI_WVALID (WVALID),
        .M_AXI_WREADY (WREADY),
        .M_AXI_BRESP  (BRESP),
        .M_AXI_BVALID (BVALID),
        .M_AXI_BREADY (BREADY),
        .M_AXI_ARADDR (ARADDR),
        .M_AXI_ARVALID(ARVALID),
        .M_AXI_ARREADY(ARREADY),
        .M_AXI_RDATA  (RDATA),
        .M_AXI_RRESP  (RRESP),
        .M_AXI_RVALID (RVALID),
        .M_AXI_RREADY (RREADY)
    );

    // ---------------- slave model ----------------
    int          aw_dly = 0, w_dly = 0, b_dly = 0, r_dly = 0;
    logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
    logic [31:0] rdata_cfg = '0;
    int          aw_wait = 0, w_wait = 0, b_wait = 0, r_wait = 0;
    bit          aw_seen = 0, w_seen = 0, ar_seen = 0;
    bit          p_aw = 0, p_w = 0, p_b = 0, p_ar = 0, p_r = 0;
    int          n_aw = 0, n_w = 0, n_ar = 0, n_viol = 0;
    logic [31:0] last_awaddr = '0, last_wdata = '0, last_araddr = '0;
    logic [3:0]  last_wstrb = '0;
    bit          saw_aw_lo_w_hi = 0, saw_w_lo_aw_hi = 0;
    bit          prev_aw_v = 0, prev_w_v = 0, prev_ar_v = 0, prev_rst = 1;

    // Slave acts on the falling edge; handshakes flagged here complete on the next rising edge
    always @(negedge clk) begin
        // a valid may only fall on its own handshake (or a reset)
        if (!prev_rst) begin
            if (prev_aw_v && !p_aw && !AWVALID) n_viol++;
            if (prev_w_v  && !p_w  && !WVALID)  n_viol++;
            if (prev_ar_v && !p_ar && !ARVALID) n_viol++;
        end
        if (p_aw) begin AWREADY = 0; aw_seen = 1; aw_wait = 0; n_aw++; end
        if (p_w)  begin WREADY  = 0; w_seen  = 1; w_wait  = 0; n_w++;  end
        if (p_b)  BVALID = 0;
        if (p_ar) begin ARREADY = 0; ar_seen = 1; n_ar++; end
        if (p_r)  RVALID = 0;
        if (ARESET) begin
            AWREADY = 0; WREADY = 0; BVALID = 0; ARREADY = 0; RVALID = 0;
            aw_seen = 0; w_seen = 0; ar_seen = 0;
            aw_wait = 0; w_wait = 0; b_wait = 0; r_wait = 0;
        end else begin
            if (AWVALID && !WVALID && !w_seen) saw_aw_lo_w_hi = saw_aw_lo_w_hi;
            if (!AWVALID && WVALID) saw_aw_lo_w_hi = 1;
            if (AWVALID && !WVALID) saw_w_lo_aw_hi = 1;
            if (AWVALID && !AWREADY) begin
                if (aw_wait >= aw_dly) AWREADY = 1; else aw_wait++;
            end
            if (WVALID && !WREADY) begin
                if (w_wait >= w_dly) WREADY = 1; else w_wait++;
            end
            if (ARVALID && !ARREADY) ARREADY = 1;
            if (aw_seen && w_seen && !BVALID) begin
                if (b_wait >= b_dly) begin
                    BVALID = 1; BRESP = bresp_cfg; aw_seen = 0; w_seen = 0; b_wait = 0;
                end else b_wait++;
            end
            if (ar_seen && !RVALID) begin
                if (r_wait >= r_dly) begin
                    RVALID = 1; RDATA = rdata_cfg; RRESP = rresp_cfg; ar_seen = 0; r_wait = 0;
                end else r_wait++;
            end
        end
        p_aw = AWVALID & AWREADY & !ARESET;
        p_w  = WVALID  & WREADY  & !ARESET;
        p_b  = BVALID  & BREADY  & !ARESET;
        p_ar = ARVALID & ARREADY & !ARESET;
        p_r  = RVALID  & RREADY  & !ARESET;
        if (p_aw) last_awaddr = AWADDR;
        if (p_w)  begin last_wdata = WDATA; last_wstrb = WSTRB; end
        if (p_ar) last_araddr = ARADDR;
        prev_aw_v = AWVALID; prev_w_v = WVALID; prev_ar_v = ARVALID;
        prev_rst  = ARESET;
    end

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Poll one cycle at a time (1 time unit after each rising edge) until a REQ_DONE pulse
    task automatic wait_done(input string tag, output int lat, output logic [1:0] done,
                             output logic [31:0] rd, output logic err);
        lat = 0; done = 2'b00; rd = '0; err = 1'b0;
        while (lat < 60 && done == 2'b00) begin
            @(posedge clk); #1;
            lat++;
            done = REQ_DONE; rd = REQ_RDATA; err = REQ_ERR;
        end
        if (done == 2'b00) check_eq({tag, "_timeout"}, 32'(lat), 32'd0);
    endtask

    task automatic run_req(input string tag, input int idx, input logic we, input logic [8:0] ofs,
                           input logic [31:0] wd, output int lat, output logic [1:0] done,
                           output logic [31:0] rd, output logic err);
        REQ_WE[idx] = we;
        REQ_ADDR[idx*9 +: 9] = ofs;
        REQ_WDATA[idx*32 +: 32] = wd;
        REQ_VALID[idx] = 1'b1;
        wait_done(tag, lat, done, rd, err);
        REQ_VALID[idx] = 1'b0;
        $display("txn %s: req%0d we=%0b ofs=%h done=%b rdata=%h err=%0b lat=%0d",
                 tag, idx, we, ofs, done, rd, err, lat);
    endtask

    task automatic pulse_reset();
        ARESET = 1'b1;
        @(posedge clk); #1;
        ARESET = 1'b0;
    endtask

    int          lat, a0, b0, exp_g, gap;
    logic [1:0]  done;
    logic [31:0] rd;
    logic        err;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ARESET = 1'b1; REQ_VALID = '0; REQ_WE = '0; REQ_ADDR = '0; REQ_WDATA = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_awvalid", 32'(AWVALID), 32'd0);
        check_eq("rst_wvalid",  32'(WVALID),  32'd0);
        check_eq("rst_arvalid", 32'(ARVALID), 32'd0);
        check_eq("rst_bready",  32'(BREADY),  32'd0);
        check_eq("rst_rready",  32'(RREADY),  32'd0);
        check_eq("rst_awaddr",  AWADDR,       32'd0);
        check_eq("rst_done",    32'(REQ_DONE), 32'd0);
        check_eq("rst_rdata",   REQ_RDATA,    32'd0);
        check_eq("rst_err",     32'(REQ_ERR), 32'd0);
        ARESET = 1'b0;

        // requester 0 write, zero-wait slave
        run_req("wr0", 0, 1'b1, 9'h004, 32'hDEADBEEF, lat, done, rd, err);
        check_eq("wr0_lat",    32'(lat),  32'd3);
        check_eq("wr0_done",   32'(done), 32'd1);
        check_eq("wr0_err",    32'(err),  32'd0);
        check_eq("wr0_awaddr", last_awaddr, 32'h70E00004);
        check_eq("wr0_wdata",  last_wdata,  32'hDEADBEEF);
        check_eq("wr0_wstrb",  32'(last_wstrb), 32'hF);

        // requester 1 read with a slow R channel
        r_dly = 5; rdata_cfg = 32'h12345678;
        run_req("rd1", 1, 1'b0, 9'h1FC, 32'h0, lat, done, rd, err);
        check_eq("rd1_done",   32'(done), 32'd2);
        check_eq("rd1_rdata",  rd,        32'h12345678);
        check_eq("rd1_err",    32'(err),  32'd0);
        check_eq("rd1_araddr", last_araddr, 32'h70E001FC);
        r_dly = 0;

        // AWREADY two cycles ahead of WREADY
        a0 = n_aw; b0 = n_w; n_viol = 0; saw_aw_lo_w_hi = 0; saw_w_lo_aw_hi = 0;
        aw_dly = 0; w_dly = 2;
        run_req("skw_aw", 0, 1'b1, 9'h010, 32'hA5A5_0001, lat, done, rd, err);
        check_eq("skw_aw_done",  32'(done), 32'd1);
        check_eq("skw_aw_rdata", rd, 32'd0);
        check_eq("skw_aw_naw",   32'(n_aw - a0), 32'd1);
        check_eq("skw_aw_nw",    32'(n_w - b0),  32'd1);
        check_eq("skw_aw_split", 32'(saw_aw_lo_w_hi), 32'd1);
        check_eq("skw_aw_wdata", last_wdata, 32'hA5A5_0001);

        // WREADY two cycles ahead of AWREADY
        a0 = n_aw; b0 = n_w; saw_aw_lo_w_hi = 0; saw_w_lo_aw_hi = 0;
        aw_dly = 2; w_dly = 0;
        run_req("skw_w", 1, 1'b1, 9'h020, 32'h5A5A_0002, lat, done, rd, err);
        check_eq("skw_w_done",   32'(done), 32'd2);
        check_eq("skw_w_naw",    32'(n_aw - a0), 32'd1);
        check_eq("skw_w_nw",     32'(n_w - b0),  32'd1);
        check_eq("skw_w_split",  32'(saw_w_lo_aw_hi), 32'd1);
        check_eq("skw_w_awaddr", last_awaddr, 32'h70E00020);
        check_eq("valid_stable", 32'(n_viol), 32'd0);
        aw_dly = 0; w_dly = 0;

        // error responses
        bresp_cfg = 2'b10;
        run_req("wr_slverr", 0, 1'b1, 9'h008, 32'h1, lat, done, rd, err);
        check_eq("wr_slverr_err", 32'(err), 32'd1);
        bresp_cfg = 2'b00;
        rresp_cfg = 2'b11; rdata_cfg = 32'hCAFE_F00D;
        run_req("rd_decerr", 1, 1'b0, 9'h00C, 32'h0, lat, done, rd, err);
        check_eq("rd_decerr_err",   32'(err), 32'd1);
        check_eq("rd_decerr_rdata", rd, 32'hCAFE_F00D);
        rresp_cfg = 2'b00;

        // both requesters held valid: grant order
        pulse_reset();
        rdata_cfg = 32'h0000_0BAD;
        REQ_WE = 2'b00; REQ_ADDR = {9'h040, 9'h030}; REQ_VALID = 2'b11;
        for (int k = 0; k < 4; k++) begin
            wait_done("arb", lat, done, rd, err);
`ifdef HAMMU_ARB_RR_EN
            exp_g = (k % 2 == 0) ? 1 : 2;
`else
            exp_g = 1;
`endif
            $display("txn arb%0d: done=%b lat=%0d", k, done, lat);
            check_eq($sformatf("arb_grant%0d", k), 32'(done), 32'(exp_g));
            if (k == 0) check_eq("arb_lat0", 32'(lat), 32'd3);
            else        check_eq($sformatf("arb_gap%0d", k), 32'(lat), 32'd4);
        end
        // requester 1 must still be waiting and is served once 0 steps back
        REQ_VALID[0] = 1'b0;
        wait_done("arb_tail", lat, done, rd, err);
        REQ_VALID[1] = 1'b0;
        $display("txn arb_tail: done=%b lat=%0d", done, lat);
        check_eq("arb_tail_grant", 32'(done), 32'd2);
        check_eq("arb_tail_addr",  last_araddr, 32'h70E00040);

        // reset during RD_R
        r_dly = 10;
        REQ_WE[1] = 1'b0; REQ_ADDR[17:9] = 9'h050; REQ_VALID[1] = 1'b1;
        gap = 0;
        while (gap < 20 && RREADY !== 1'b1) begin
            @(posedge clk); #1;
            gap++;
        end
        check_eq("mid_rst_reach_rd_r", 32'(RREADY), 32'd1);
        ARESET = 1'b1; REQ_VALID = 2'b00;
        @(posedge clk); #1;
        check_eq("mid_rst_rready",  32'(RREADY),  32'd0);
        check_eq("mid_rst_arvalid", 32'(ARVALID), 32'd0);
        check_eq("mid_rst_araddr",  ARADDR,       32'd0);
        check_eq("mid_rst_wdata",   WDATA,        32'd0);
        check_eq("mid_rst_done",    32'(REQ_DONE), 32'd0);
        ARESET = 1'b0;
        gap = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            if (REQ_DONE != 2'b00) gap++;
        end
        check_eq("mid_rst_no_done", 32'(gap), 32'd0);
        r_dly = 0;
        run_req("post_rst", 0, 1'b1, 9'h0F0, 32'h0BAD_CAFE, lat, done, rd, err);
        check_eq("post_rst_lat",    32'(lat),  32'd3);
        check_eq("post_rst_done",   32'(done), 32'd1);
        check_eq("post_rst_awaddr", last_awaddr, 32'h70E000F0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
